// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and codes for the two-port memory arbiter.
// Request sizes, response codes and FSM state encodings.
package mem_port_arbiter_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int MEM_COUNT_W = 3;
  localparam int MEM_CODE_W  = 3;

  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 3'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 3'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 3'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 3'd4;

  localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID       = 3'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ          = 3'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE         = 3'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED    = 3'd3;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_OUT_OF_BOUNDS = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]      addr;
    logic [WORD_W-1:0]      wr_data;
    logic                   wr_en;
    logic [MEM_COUNT_W-1:0] count;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Winner select between the two pending ports.
// MEM_ARB_RR_EN: round-robin on rr_ptr (1 = prefer B), else B wins.
module mem_arb_grant (
`ifdef MEM_ARB_RR_EN
  input  logic       rr_ptr,
`endif
  input  logic       pending_a,
  input  logic       pending_b,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
`ifdef MEM_ARB_RR_EN
    if (pending_a && pending_b) begin
      grant = rr_ptr ? 2'b10 : 2'b01;
    end else begin
      grant = {pending_b, pending_a};
    end
`else
    if (pending_b) begin
      grant = 2'b10;
    end else if (pending_a) begin
      grant = 2'b01;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one memory-mapped device.
// Define MEM_ARB_RR_EN for round-robin, otherwise B has fixed priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEV_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      i_a_req_addr,
  input  logic [WORD_W-1:0]      i_a_req_wr_data,
  input  logic                   i_a_req_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_a_req_count,
  output logic [WORD_W-1:0]      o_a_res_rd_data,
  output logic [MEM_CODE_W-1:0]  o_a_res_code,
  output logic                   o_a_res_valid,
  input  logic [ADDR_W-1:0]      i_b_req_addr,
  input  logic [WORD_W-1:0]      i_b_req_wr_data,
  input  logic                   i_b_req_wr_en,
  input  logic [MEM_COUNT_W-1:0] i_b_req_count,
  output logic [WORD_W-1:0]      o_b_res_rd_data,
  output logic [MEM_CODE_W-1:0]  o_b_res_code,
  output logic                   o_b_res_valid,
  output logic [ADDR_W-1:0]      o_dev_req_addr,
  output logic [WORD_W-1:0]      o_dev_req_wr_data,
  output logic                   o_dev_req_wr_en,
  output logic [MEM_COUNT_W-1:0] o_dev_req_count,
  input  logic [WORD_W-1:0]      i_dev_res_rd_data,
  input  logic [MEM_CODE_W-1:0]  i_dev_res_code,
  output logic [1:0]             o_grant
);

  localparam int CNT_W = (DEV_LATENCY > 2) ? $clog2(DEV_LATENCY) : 1;

  arb_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             grant_q, grant_d;
  mem_req_t               dreq_q, dreq_d;
  logic [WORD_W-1:0]      a_rd_q, a_rd_d, b_rd_q, b_rd_d;
  logic [MEM_CODE_W-1:0]  a_code_q, a_code_d, b_code_q, b_code_d;
  logic                   a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  mem_req_t               a_req, b_req;
  logic                   pend_a, pend_b;
  logic [1:0]             win;
`ifdef MEM_ARB_RR_EN
  logic                   rr_ptr_q, rr_ptr_d;
`endif

  assign a_req = '{addr: i_a_req_addr, wr_data: i_a_req_wr_data,
                   wr_en: i_a_req_wr_en, count: i_a_req_count};
  assign b_req = '{addr: i_b_req_addr, wr_data: i_b_req_wr_data,
                   wr_en: i_b_req_wr_en, count: i_b_req_count};

  // A port whose response strobes this cycle still shows its old request
  assign pend_a = (i_a_req_count != MEM_COUNT_NONE) && !a_vld_q;
  assign pend_b = (i_b_req_count != MEM_COUNT_NONE) && !b_vld_q;

  mem_arb_grant u_grant (
`ifdef MEM_ARB_RR_EN
    .rr_ptr    (rr_ptr_q),
`endif
    .pending_a (pend_a),
    .pending_b (pend_b),
    .grant     (win)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_d  = grant_q;
    dreq_d   = dreq_q;
    a_rd_d   = a_rd_q;
    a_code_d = a_code_q;
    b_rd_d   = b_rd_q;
    b_code_d = b_code_q;
    a_vld_d  = 1'b0;
    b_vld_d  = 1'b0;
`ifdef MEM_ARB_RR_EN
    rr_ptr_d = rr_ptr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        dreq_d.count = MEM_COUNT_NONE;
        if (|win) begin
          dreq_d  = win[1] ? b_req : a_req;
          grant_d = win;
          state_d = ST_ISSUE;
`ifdef MEM_ARB_RR_EN
          rr_ptr_d = win[0];
`endif
        end
      end
      ST_ISSUE: begin
        dreq_d.count = MEM_COUNT_NONE;
        cnt_d        = CNT_W'(DEV_LATENCY - 1);
        state_d      = (DEV_LATENCY == 1) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (grant_q[0]) begin
          a_rd_d   = i_dev_res_rd_data;
          a_code_d = i_dev_res_code;
          a_vld_d  = 1'b1;
        end else begin
          b_rd_d   = i_dev_res_rd_data;
          b_code_d = i_dev_res_code;
          b_vld_d  = 1'b1;
        end
        grant_d = 2'b00;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      grant_q  <= 2'b00;
      dreq_q   <= '{addr: '0, wr_data: '0, wr_en: 1'b0,
                    count: MEM_COUNT_NONE};
      a_rd_q   <= '0;
      a_code_q <= MEM_CODE_INVALID;
      a_vld_q  <= 1'b0;
      b_rd_q   <= '0;
      b_code_q <= MEM_CODE_INVALID;
      b_vld_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
      rr_ptr_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      dreq_q   <= dreq_d;
      a_rd_q   <= a_rd_d;
      a_code_q <= a_code_d;
      a_vld_q  <= a_vld_d;
      b_rd_q   <= b_rd_d;
      b_code_q <= b_code_d;
      b_vld_q  <= b_vld_d;
`ifdef MEM_ARB_RR_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  assign o_a_res_rd_data   = a_rd_q;
  assign o_a_res_code      = a_code_q;
  assign o_a_res_valid     = a_vld_q;
  assign o_b_res_rd_data   = b_rd_q;
  assign o_b_res_code      = b_code_q;
  assign o_b_res_valid     = b_vld_q;
  assign o_dev_req_addr    = dreq_q.addr;
  assign o_dev_req_wr_data = dreq_q.wr_data;
  assign o_dev_req_wr_en   = dreq_q.wr_en;
  assign o_dev_req_count   = dreq_q.count;
  assign o_grant           = grant_q;

endmodule
